// File: rtl/conv_pkg.sv
// Shared constants and index helpers for the streaming convolution engine.
package conv_pkg;

    // Cycles from the accepting edge to conv_op/valid_conv.
    localparam int unsigned CONV_LAT = 2;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of tap (ch,i,j) inside a flattened C*K*K*DW window or kernel.
    function automatic int unsigned tap_off(input int unsigned ch, input int unsigned i,
                                            input int unsigned j, input int unsigned k,
                                            input int unsigned dw);
        return ((ch * k + i) * k + j) * dw;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Row FIFOs plus a KxK window per channel; everything shifts only on accept.
// Contents are not reset: no window is reported before K-1 rows refill.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 3,
    parameter int unsigned C  = 1,
    parameter int unsigned DW = 16
) (
    input  logic                  clk,
    input  logic                  shift,
    input  logic [C*DW-1:0]       pixel,
    output logic [C*K*K*DW-1:0]   window
);

    logic [DW-1:0] lb  [C][K-1][N];
    logic [DW-1:0] win [C][K][K];

    // Row FIFOs: FIFO m delays the pixel stream by (m+1) rows.
    always_ff @(posedge clk) begin
        if (shift) begin
            for (int unsigned ch = 0; ch < C; ch++) begin
                lb[ch][0][0] <= pixel[ch*DW +: DW];
                for (int unsigned m = 1; m < K-1; m++) begin
                    lb[ch][m][0] <= lb[ch][m-1][N-1];
                end
                for (int unsigned m = 0; m < K-1; m++) begin
                    for (int unsigned n = 1; n < N; n++) begin
                        lb[ch][m][n] <= lb[ch][m][n-1];
                    end
                end
            end
        end
    end

    // Window shifts left; the new right column is the FIFO taps plus the live pixel.
    always_ff @(posedge clk) begin
        if (shift) begin
            for (int unsigned ch = 0; ch < C; ch++) begin
                for (int unsigned i = 0; i < K; i++) begin
                    for (int unsigned j = 0; j < K-1; j++) begin
                        win[ch][i][j] <= win[ch][i][j+1];
                    end
                end
                for (int unsigned i = 0; i < K-1; i++) begin
                    win[ch][i][K-1] <= lb[ch][K-2-i][N-1];
                end
                win[ch][K-1][K-1] <= pixel[ch*DW +: DW];
            end
        end
    end

    // Flatten the window in kernel tap order.
    always_comb begin
        window = '0;
        for (int unsigned ch = 0; ch < C; ch++) begin
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    window[tap_off(ch, i, j, K, DW) +: DW] = win[ch][i][j];
                end
            end
        end
    end

endmodule

// File: rtl/conv_engine_mc.sv
// Streaming multi-channel 2D convolution: raster pixels in, one summed result
// per strided window out, two-stage MAC pipeline gated by ce.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
module conv_engine_mc
    import conv_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 3,
    parameter int unsigned S  = 1,
    parameter int unsigned C  = 1,
    parameter int unsigned DW = 16,
    parameter int unsigned OW = 40
) (
    input  logic                  clk,
    input  logic                  global_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [C*DW-1:0]       activation,
    input  logic [C*K*K*DW-1:0]   weight1,
    output logic signed [OW-1:0]  conv_op,
    output logic                  valid_conv,
    output logic                  end_conv
);

    localparam int unsigned CW   = cnt_w(N);
    localparam int unsigned TAPS = C * K * K;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned KM1  = K - 1;

    logic [CW-1:0]         row_q, col_q;
    logic                  accept_c, col_last_c, row_last_c, hit_c;
    logic [CONV_LAT-1:0]   vld_q, end_q;
    logic [C*K*K*DW-1:0]   window_c;
    logic signed [PW-1:0]  prod_c [TAPS];
    logic signed [PW-1:0]  prod_q [TAPS];
    logic signed [OW-1:0]  sum_c, res_c;

    assign accept_c   = ce & in_valid;
    assign col_last_c = (col_q == CW'(N - 1));
    assign row_last_c = (row_q == CW'(N - 1));
    assign hit_c      = (32'(row_q) >= KM1) && (32'(col_q) >= KM1) &&
                        (((32'(row_q) - KM1) % S) == 32'd0) &&
                        (((32'(col_q) - KM1) % S) == 32'd0);

    conv_line_buffer #(.N(N), .K(K), .C(C), .DW(DW)) u_lb (
        .clk    (clk),
        .shift  (accept_c),
        .pixel  (activation),
        .window (window_c)
    );

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept_c) begin
            if (col_last_c) begin
                col_q <= '0;
                row_q <= row_last_c ? '0 : row_q + CW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Signed tap products; weights are taken live as the window enters stage 1.
    for (genvar t = 0; t < TAPS; t++) begin : g_mul
        logic signed [PW-1:0] a_ext, w_ext;
        assign a_ext     = PW'($signed(window_c[t*DW +: DW]));
        assign w_ext     = PW'($signed(weight1[t*DW +: DW]));
        assign prod_c[t] = a_ext * w_ext;
    end

    // Stage 1 product registers; data needs no reset, the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (ce) begin
            prod_q <= prod_c;
        end
    end

    // Adder tree over all channels and taps, sign-extended to the output width.
    always_comb begin
        sum_c = '0;
        for (int unsigned t = 0; t < TAPS; t++) begin
            sum_c = sum_c + OW'(prod_q[t]);
        end
    end

`ifdef CONV_RELU_EN
    assign res_c = sum_c[OW-1] ? '0 : sum_c;
`else
    assign res_c = sum_c;
`endif

    // Window/frame flags travel alongside the data; stage 2 loads only on a valid window.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            vld_q      <= '0;
            end_q      <= '0;
            valid_conv <= 1'b0;
            end_conv   <= 1'b0;
            conv_op    <= '0;
        end else if (ce) begin
            vld_q      <= {vld_q[CONV_LAT-2:0], accept_c & hit_c};
            end_q      <= {end_q[CONV_LAT-2:0], accept_c & col_last_c & row_last_c};
            valid_conv <= vld_q[CONV_LAT-1];
            end_conv   <= end_q[CONV_LAT-1];
            if (vld_q[CONV_LAT-1]) begin
                conv_op <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_conv_engine_mc.sv
// Bench for conv_engine_mc: two instances (N4/S1/C2 and N5/S2/C1), one active at
// a time; a case table drives frames, and a per-cycle monitor checks every output
// against a queue of expected results stamped with their due ce-cycle.
module tb_conv_engine_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ce = 1'b0;
    logic in_valid = 1'b0;
    logic sel = 1'b0;

    logic [31:0]         act_a = '0;
    logic [2*9*16-1:0]   w_a = '0;
    logic signed [39:0]  conv_a;
    logic                vld_a, end_a;

    logic [15:0]         act_b = '0;
    logic [9*16-1:0]     w_b = '0;
    logic signed [39:0]  conv_b;
    logic                vld_b, end_b;

    logic ce_a, ce_b;
    assign ce_a = ce & ~sel;
    assign ce_b = ce & sel;

    conv_engine_mc #(.N(4), .K(3), .S(1), .C(2), .DW(16), .OW(40)) dut_a (
        .clk(clk), .global_rst(rst), .ce(ce_a), .in_valid(in_valid),
        .activation(act_a), .weight1(w_a),
        .conv_op(conv_a), .valid_conv(vld_a), .end_conv(end_a)
    );

    conv_engine_mc #(.N(5), .K(3), .S(2), .C(1), .DW(16), .OW(40)) dut_b (
        .clk(clk), .global_rst(rst), .ce(ce_b), .in_valid(in_valid),
        .activation(act_b), .weight1(w_b),
        .conv_op(conv_b), .valid_conv(vld_b), .end_conv(end_b)
    );

    logic signed [39:0] cur_conv;
    logic cur_v, cur_e;
    assign cur_conv = sel ? conv_b : conv_a;
    assign cur_v    = sel ? vld_b : vld_a;
    assign cur_e    = sel ? end_b : end_a;

    typedef struct {
        longint due;
        bit     v;
        bit     e;
        longint val;
    } exp_t;

    typedef struct packed {
        bit                        sel;
        int                        n;
        int                        s;
        int                        w0;      // 0: 3i+j, 1: all 1, 2: all -1
        int                        a0;      // 0: raster index, 1: all 1
        bit                        ch1;     // ch1 weights and activation all 1 (else 0)
        int                        frames;
        int                        stall1;  // 3 ce=0 cycles after this pixel
        int                        stall2;  // 2 ce=0 cycles after this pixel
        int                        gap1;    // one in_valid=0 cycle after this pixel
        int                        gap2;
        logic signed [3:0][39:0]   expv;
    } case_t;

    exp_t   sb[$];
    longint ce_cnt = 0;
    bit     last_ce = 1'b0;
    bit     exp_v = 1'b0, exp_e = 1'b0;
    longint exp_conv = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input longint act, input longint expd);
        checks++;
        if (act != expd) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (ce-cycle %0d, t=%0t)",
                     name, act, expd, ce_cnt, $time);
        end
    endtask

    // Count ce edges so expected results can be stamped with their due cycle.
    always @(posedge clk) begin
        last_ce = ce;
        if (ce) ce_cnt++;
    end

    // Per-cycle output model: new result when due, otherwise idle or frozen.
    always @(negedge clk) begin
        if (rst) begin
            exp_v = 1'b0; exp_e = 1'b0; exp_conv = 0;
        end else if (last_ce) begin
            if (sb.size() > 0 && sb[0].due < ce_cnt) begin
                chk("late_result_due", ce_cnt, sb[0].due);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == ce_cnt) begin
                exp_v = sb[0].v;
                exp_e = sb[0].e;
                if (sb[0].v) exp_conv = sb[0].val;
                void'(sb.pop_front());
            end else begin
                exp_v = 1'b0; exp_e = 1'b0;
            end
        end
        chk("valid_conv", longint'(cur_v), longint'(exp_v));
        chk("end_conv",   longint'(cur_e), longint'(exp_e));
        chk("conv_op",    longint'(cur_conv), exp_conv);
    end

    task automatic step(input bit ce_v, input bit iv, input int a0, input int a1);
        ce       = ce_v;
        in_valid = iv;
        act_a    = {16'(a1), 16'(a0)};
        act_b    = 16'(a0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input int w0, input bit ch1);
        int wv;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wv = (w0 == 0) ? (3*i + j) : ((w0 == 1) ? 1 : -1);
                w_a[((0*3 + i)*3 + j)*16 +: 16] = 16'(wv);
                w_a[((1*3 + i)*3 + j)*16 +: 16] = ch1 ? 16'd1 : 16'd0;
                w_b[((0*3 + i)*3 + j)*16 +: 16] = 16'(wv);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        rst = 1'b0;
    endtask

    // Drive pixels [first, last_px] of a frame; windows take values from cs.expv in order.
    task automatic drive_frame(input case_t cs, input int first, input int last_px, inout int widx);
        int r, c, a0;
        bit win, lst;
        exp_t it;
        for (int k = first; k <= last_px; k++) begin
            r   = k / cs.n;
            c   = k % cs.n;
            a0  = (cs.a0 == 0) ? k : 1;
            step(1'b1, 1'b1, a0, cs.ch1 ? 1 : 0);
            win = (r >= 2) && (c >= 2) && ((r - 2) % cs.s == 0) && ((c - 2) % cs.s == 0);
            lst = (r == cs.n - 1) && (c == cs.n - 1);
            if (win || lst) begin
                it.due = ce_cnt + 2;
                it.v   = win;
                it.e   = lst;
                it.val = win ? longint'($signed(cs.expv[widx % 4])) : 0;
                if (win) widx++;
                sb.push_back(it);
            end
            if (k == cs.stall1) repeat (3) step(1'b0, 1'b1, int'($urandom_range(0, 999)), 7);
            if (k == cs.stall2) repeat (2) step(1'b0, 1'b0, 0, 0);
            if (k == cs.gap1 || k == cs.gap2) step(1'b1, 1'b0, int'($urandom_range(0, 999)), 5);
        end
    endtask

    task automatic drain();
        repeat (5) step(1'b1, 1'b0, 0, 0);
        chk("pending_results", longint'(sb.size()), 0);
    endtask

    case_t cases[6];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int widx;
        logic signed [3:0][39:0] neg_exp;
`ifdef CONV_RELU_EN
        neg_exp = {4{40'sd0}};
`else
        neg_exp = {4{-40'sd9}};
`endif
        cases[0] = '{sel:1'b0, n:4, s:1, w0:0, a0:0, ch1:1'b0, frames:2,
                     stall1:-1, stall2:-1, gap1:-1, gap2:-1,
                     expv:{40'sd438, 40'sd402, 40'sd294, 40'sd258}};
        cases[1] = '{sel:1'b0, n:4, s:1, w0:0, a0:0, ch1:1'b0, frames:1,
                     stall1:9, stall2:12, gap1:5, gap2:12,
                     expv:{40'sd438, 40'sd402, 40'sd294, 40'sd258}};
        cases[2] = '{sel:1'b1, n:5, s:2, w0:1, a0:0, ch1:1'b0, frames:1,
                     stall1:-1, stall2:-1, gap1:-1, gap2:-1,
                     expv:{40'sd162, 40'sd144, 40'sd72, 40'sd54}};
        cases[3] = '{sel:1'b0, n:4, s:1, w0:0, a0:0, ch1:1'b1, frames:1,
                     stall1:-1, stall2:-1, gap1:-1, gap2:-1,
                     expv:{40'sd447, 40'sd411, 40'sd303, 40'sd267}};
        cases[4] = '{sel:1'b0, n:4, s:1, w0:2, a0:1, ch1:1'b0, frames:1,
                     stall1:-1, stall2:-1, gap1:-1, gap2:-1,
                     expv:neg_exp};
        cases[5] = cases[0];
        cases[5].frames = 1;

        step(1'b0, 1'b0, 0, 0);
        for (int ci = 0; ci < 5; ci++) begin
            sel = cases[ci].sel;
            set_weights(cases[ci].w0, cases[ci].ch1);
            do_reset();
            widx = 0;
            for (int f = 0; f < cases[ci].frames; f++) begin
                drive_frame(cases[ci], 0, cases[ci].n * cases[ci].n - 1, widx);
            end
            drain();
        end

        // Reset mid-frame: the window at pixel 10 is in flight and must be dropped.
        sel = 1'b0;
        set_weights(0, 1'b0);
        do_reset();
        widx = 0;
        drive_frame(cases[5], 0, 10, widx);
        do_reset();
        widx = 0;
        drive_frame(cases[5], 0, 15, widx);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
